// File: rtl/fwd_result_pipe.sv
// Result-carrying pipeline tail: a DEPTH-stage chain of result entries with
// youngest-first operand forwarding, load-use stall request and write-back port.
module fwd_result_pipe #(
    parameter int XLEN       = 32,
    parameter int REGW       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int NSRC       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [REGW-1:0]      in_rd,
    input  logic                 in_regwrite,
    input  logic                 in_is_load,
    input  logic [XLEN-1:0]      in_data,
    input  logic [XLEN-1:0]      ld_data,
    input  logic [NSRC*REGW-1:0] src_idx,
    output logic [NSRC-1:0]      fwd_hit,
    output logic [NSRC*XLEN-1:0] fwd_data,
    output logic                 stall_req,
    output logic                 wb_we,
    output logic [REGW-1:0]      wb_rd,
    output logic [XLEN-1:0]      wb_data
);

    logic [DEPTH-1:0]           vld_q;
    logic [DEPTH-1:0]           we_q;
    logic [DEPTH-1:0]           rdy_q;
    logic [DEPTH-1:0][REGW-1:0] rd_q;
    logic [DEPTH-1:0][XLEN-1:0] data_q;
    // The load flag is only needed until the entry reaches the capture stage.
    logic [LOAD_STAGE-1:0]      ld_q;
    logic [NSRC-1:0]            stall_v;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            we_q   <= '0;
            rdy_q  <= '1;
            rd_q   <= '0;
            data_q <= '0;
            ld_q   <= '0;
        end else if (hold) begin
            if (flush) begin
                vld_q[0] <= 1'b0;
            end
        end else begin
            vld_q[0]  <= in_valid & ~flush;
            rd_q[0]   <= in_rd;
            we_q[0]   <= in_regwrite;
            rdy_q[0]  <= ~in_is_load;
            data_q[0] <= in_is_load ? '0 : in_data;
            ld_q[0]   <= in_is_load;
            for (int k = 1; k < LOAD_STAGE; k++) begin
                ld_q[k] <= ld_q[k-1];
            end
            for (int k = 1; k < DEPTH; k++) begin
                vld_q[k] <= vld_q[k-1];
                rd_q[k]  <= rd_q[k-1];
                we_q[k]  <= we_q[k-1];
                if (k == LOAD_STAGE && vld_q[k-1] && ld_q[LOAD_STAGE-1]) begin
                    data_q[k] <= ld_data;
                    rdy_q[k]  <= 1'b1;
                end else begin
                    data_q[k] <= data_q[k-1];
                    rdy_q[k]  <= rdy_q[k-1];
                end
            end
        end
    end

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [REGW-1:0] src;
        logic            hit;
        logic            rdy;
        logic [XLEN-1:0] dat;

        assign src = src_idx[i*REGW +: REGW];

        // Scan oldest to youngest so the youngest match is the last one written.
        always_comb begin
            hit = 1'b0;
            rdy = 1'b1;
            dat = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (vld_q[k] && we_q[k] && (rd_q[k] == src) && (src != '0)) begin
                    hit = 1'b1;
                    rdy = rdy_q[k];
                    dat = data_q[k];
                end
            end
        end

        assign fwd_hit[i]               = hit;
        assign fwd_data[i*XLEN +: XLEN] = dat;
        assign stall_v[i]               = hit & ~rdy;
    end

    assign stall_req = |stall_v;
    assign wb_we     = vld_q[DEPTH-1] & we_q[DEPTH-1] & (rd_q[DEPTH-1] != '0);
    assign wb_rd     = rd_q[DEPTH-1];
    assign wb_data   = data_q[DEPTH-1];

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Directed bench for fwd_result_pipe: default instance plus a DEPTH=4/XLEN=64
// instance; retirements are checked against a queue of expected write-backs.
module tb_fwd_result_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic        hold_a, flush_a, iv_a, iwe_a, ild_a;
    logic [4:0]  ird_a;
    logic [31:0] idata_a, ld_a;
    logic [9:0]  src_a;
    logic [1:0]  hit_a;
    logic [63:0] fd_a;
    logic        st_a, we_a;
    logic [4:0]  wrd_a;
    logic [31:0] wdat_a;

    logic         hold_b, flush_b, iv_b, iwe_b, ild_b;
    logic [4:0]   ird_b;
    logic [63:0]  idata_b, ld_b;
    logic [14:0]  src_b;
    logic [2:0]   hit_b;
    logic [191:0] fd_b;
    logic         st_b, we_b;
    logic [4:0]   wrd_b;
    logic [63:0]  wdat_b;

    int ntests = 0;
    int nfail  = 0;
    int stalls;
    logic [36:0] q_a[$];
    logic [68:0] q_b[$];
    logic [36:0] ea;
    logic [68:0] eb;
    logic adv_a = 1'b0;
    logic adv_b = 1'b0;

    fwd_result_pipe dut_a (
        .clk(clk), .reset(rst), .hold(hold_a), .flush(flush_a),
        .in_valid(iv_a), .in_rd(ird_a), .in_regwrite(iwe_a), .in_is_load(ild_a),
        .in_data(idata_a), .ld_data(ld_a), .src_idx(src_a),
        .fwd_hit(hit_a), .fwd_data(fd_a), .stall_req(st_a),
        .wb_we(we_a), .wb_rd(wrd_a), .wb_data(wdat_a)
    );

    fwd_result_pipe #(.XLEN(64), .REGW(5), .DEPTH(4), .LOAD_STAGE(2), .NSRC(3)) dut_b (
        .clk(clk), .reset(rst), .hold(hold_b), .flush(flush_b),
        .in_valid(iv_b), .in_rd(ird_b), .in_regwrite(iwe_b), .in_is_load(ild_b),
        .in_data(idata_b), .ld_data(ld_b), .src_idx(src_b),
        .fwd_hit(hit_b), .fwd_data(fd_b), .stall_req(st_b),
        .wb_we(we_b), .wb_rd(wrd_b), .wb_data(wdat_b)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic acc_a(input logic [4:0] rd, input logic [31:0] d, input logic we, input logic ld);
        iv_a = 1'b1; ird_a = rd; idata_a = d; iwe_a = we; ild_a = ld;
        step();
        iv_a = 1'b0;
    endtask

    task automatic acc_b(input logic [4:0] rd, input logic [63:0] d, input logic we, input logic ld);
        iv_b = 1'b1; ird_b = rd; idata_b = d; iwe_b = we; ild_b = ld;
        step();
        iv_b = 1'b0;
    endtask

    // A write-back is new only if the chain advanced at the preceding edge.
    always @(posedge clk) begin
        adv_a <= !hold_a && !rst;
        adv_b <= !hold_b && !rst;
    end

    always @(negedge clk) begin
        if (adv_a && we_a === 1'b1) begin
            chk("wb_a_expected", q_a.size() != 0, 1);
            if (q_a.size() != 0) begin
                ea = q_a.pop_front();
                chk("wb_a_rd", wrd_a, ea[36:32]);
                chk("wb_a_data", wdat_a, ea[31:0]);
            end
        end
        if (adv_b && we_b === 1'b1) begin
            chk("wb_b_expected", q_b.size() != 0, 1);
            if (q_b.size() != 0) begin
                eb = q_b.pop_front();
                chk("wb_b_rd", wrd_b, eb[68:64]);
                chk("wb_b_data", wdat_b, eb[63:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        hold_a = 0; flush_a = 0; iv_a = 0; iwe_a = 0; ild_a = 0; ird_a = 0;
        idata_a = 0; ld_a = 0; src_a = 0;
        hold_b = 0; flush_b = 0; iv_b = 0; iwe_b = 0; ild_b = 0; ird_b = 0;
        idata_b = 0; ld_b = 0; src_b = 0;
        step();
        step();
        src_a = {5'd5, 5'd3};
        src_b = {5'd1, 5'd2, 5'd3};
        #1;
        chk("rst_hit_a", hit_a, 0);
        chk("rst_fd_a", fd_a, 0);
        chk("rst_stall_a", st_a, 0);
        chk("rst_we_a", we_a, 0);
        chk("rst_rd_a", wrd_a, 0);
        chk("rst_wdat_a", wdat_a, 0);
        chk("rst_hit_b", hit_b, 0);
        chk("rst_stall_b", st_b, 0);
        chk("rst_we_b", we_b, 0);
        rst = 1'b0;
        step();

        // reset mid-stream: only the first entry retires before reset hits
        q_a.push_back({5'd1, 32'd1});
        acc_a(5'd1, 32'd1, 1, 0);
        acc_a(5'd2, 32'd2, 1, 0);
        acc_a(5'd3, 32'd3, 1, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        src_a = {5'd3, 5'd2};
        #1;
        chk("mrst_hit", hit_a, 0);
        chk("mrst_fd", fd_a, 0);
        chk("mrst_stall", st_a, 0);
        chk("mrst_we", we_a, 0);
        chk("mrst_rd", wrd_a, 0);
        chk("mrst_wdat", wdat_a, 0);
        step();
        step();

        // straight flow
        q_a.push_back({5'd5, 32'h11});
        acc_a(5'd5, 32'h11, 1, 0);
        src_a = {5'd0, 5'd5};
        #1;
        chk("flow_hit", hit_a, 2'b01);
        chk("flow_fd", fd_a[31:0], 32'h11);
        chk("flow_stall", st_a, 0);
        step();
        chk("flow_we_t1", we_a, 0);
        step();
        chk("flow_we_t2", we_a, 1);
        chk("flow_rd_t2", wrd_a, 5);
        step();

        // youngest priority and rd=0 never forwards
        q_a.push_back({5'd7, 32'hAA});
        q_a.push_back({5'd7, 32'hBB});
        acc_a(5'd7, 32'hAA, 1, 0);
        acc_a(5'd7, 32'hBB, 1, 0);
        acc_a(5'd0, 32'h55, 1, 0);
        src_a = {5'd0, 5'd7};
        #1;
        chk("young_hit", hit_a, 2'b01);
        chk("young_fd", fd_a, {32'h0, 32'hBB});
        step(); step(); step();
        acc_a(5'd9, 32'h99, 0, 0);
        src_a = {5'd0, 5'd9};
        #1;
        chk("nowe_hit", hit_a, 0);
        step(); step(); step();

        // load-use
        q_a.push_back({5'd3, 32'hDEAD});
        acc_a(5'd3, 32'h1234, 1, 1);
        src_a = {5'd0, 5'd3};
        #1;
        chk("lu_stall", st_a, 1);
        chk("lu_hit", hit_a, 2'b01);
        chk("lu_fd_zero", fd_a[31:0], 0);
        ld_a = 32'hDEAD;
        step();
        ld_a = 32'h0;
        chk("lu_stall_after", st_a, 0);
        chk("lu_fd_after", fd_a[31:0], 32'hDEAD);
        step(); step(); step();

        // younger not-ready load shadows an older ready ALU result
        q_a.push_back({5'd4, 32'h44});
        q_a.push_back({5'd4, 32'h77});
        acc_a(5'd4, 32'h44, 1, 0);
        acc_a(5'd4, 32'h0, 1, 1);
        src_a = {5'd0, 5'd4};
        #1;
        chk("shadow_stall", st_a, 1);
        chk("shadow_fd", fd_a[31:0], 0);
        ld_a = 32'h77;
        step();
        ld_a = 32'h0;
        chk("shadow_stall_after", st_a, 0);
        chk("shadow_fd_after", fd_a[31:0], 32'h77);
        step(); step(); step();

        // hold with flush: stage 0 squashed, older entries kept and retire in order
        q_a.push_back({5'd10, 32'hA0});
        q_a.push_back({5'd11, 32'hB0});
        acc_a(5'd10, 32'hA0, 1, 0);
        acc_a(5'd11, 32'hB0, 1, 0);
        acc_a(5'd12, 32'hC0, 1, 0);
        hold_a = 1; flush_a = 1;
        iv_a = 1; ird_a = 5'd13; idata_a = 32'hD0; iwe_a = 1; ild_a = 0;
        step();
        flush_a = 0; iv_a = 0;
        src_a = {5'd11, 5'd12};
        #1;
        chk("hf_hit", hit_a, 2'b10);
        chk("hf_fd", fd_a[63:32], 32'hB0);
        chk("hf_wb_rd", wrd_a, 10);
        step();
        chk("hold_wb_rd", wrd_a, 10);
        chk("hold_wb_we", we_a, 1);
        hold_a = 0;
        step(); step(); step();

        // flush without hold leaves a bubble
        iv_a = 1; ird_a = 5'd14; idata_a = 32'hE0; iwe_a = 1; ild_a = 0; flush_a = 1;
        step();
        iv_a = 0; flush_a = 0;
        src_a = {5'd0, 5'd14};
        #1;
        chk("flush_hit", hit_a, 0);
        step(); step(); step();
        chk("a_drained", q_a.size(), 0);

        // DEPTH=4 instance: four advances to leave
        q_b.push_back({5'd6, 64'h1122334455667788});
        acc_b(5'd6, 64'h1122334455667788, 1, 0);
        step();
        chk("b_lat_t1", we_b, 0);
        step();
        chk("b_lat_t2", we_b, 0);
        step();
        chk("b_lat_t3", we_b, 1);
        step();

        // LOAD_STAGE=2: two stall cycles before the load data is forwardable
        stalls = 0;
        q_b.push_back({5'd8, 64'hCAFEF00D12345678});
        acc_b(5'd8, 64'h99, 1, 1);
        src_b = {5'd0, 5'd0, 5'd8};
        #1;
        if (st_b === 1'b1) stalls++;
        ld_b = 64'hBAD;
        step();
        if (st_b === 1'b1) stalls++;
        chk("b_lu_fd_zero", fd_b[63:0], 0);
        ld_b = 64'hCAFEF00D12345678;
        step();
        ld_b = 64'h0;
        chk("b_lu_stall_after", st_b, 0);
        chk("b_lu_fd_after", fd_b[63:0], 64'hCAFEF00D12345678);
        chk("b_stall_cycles", stalls, 2);
        step(); step(); step();

        // independent per-operand hits
        q_b.push_back({5'd1, 64'h100});
        q_b.push_back({5'd2, 64'h200});
        acc_b(5'd1, 64'h100, 1, 0);
        acc_b(5'd2, 64'h200, 1, 0);
        src_b = {5'd3, 5'd2, 5'd1};
        #1;
        chk("b_ops_hit", hit_b, 3'b011);
        chk("b_op0_fd", fd_b[63:0], 64'h100);
        chk("b_op1_fd", fd_b[127:64], 64'h200);
        chk("b_op2_fd", fd_b[191:128], 0);
        step(); step(); step(); step();
        chk("b_drained", q_b.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/fwd_result_pipe.md
# fwd_result_pipe

Parametrised result-carrying pipeline tail for the pipelined RISC-V core. It replaces the fixed, hand-instantiated EX/MEM and MEM/WB register banks with a DEPTH-stage chain of result entries, each holding a valid bit, destination register, write-enable, load flag, data word and data-ready flag. It resolves operand forwarding for NSRC source operands, youngest match first, and raises a load-use stall request. It supports a whole-chain hold and a stage-0 flush.

## Interface
- XLEN, 32, data width
- REGW, 5, register-index width
- DEPTH, 3, number of chain stages (≥2); stage 0 = youngest
- LOAD_STAGE, 1, stage at which load data becomes valid (1 ≤ LOAD_STAGE ≤ DEPTH-1)
- NSRC, 2, number of forwarding source operands

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- hold  in  1  freeze stages 1..DEPTH-1 and do not accept input
- flush  in  1  clear stage 0 (squash entry)
- in_valid  in  1  entry offered for stage 0
- in_rd  in  REGW  destination register
- in_regwrite  in  1  entry writes the register file
- in_is_load  in  1  entry's data comes from ld_data
- in_data  in  XLEN  ALU result; ignored when in_is_load
- ld_data  in  XLEN  memory read data for the entry in stage LOAD_STAGE-1
- src_idx  in  NSRC*REGW  source register indices, operand i at [i*REGW +: REGW]
- fwd_hit  out  NSRC  operand i has a forwarding match
- fwd_data  out  NSRC*XLEN  forwarded value per operand
- stall_req  out  1  a matched youngest entry is a load whose data is not ready
- wb_we  out  1  register-file write enable from stage DEPTH-1
- wb_rd  out  REGW  register-file write address
- wb_data  out  XLEN  register-file write data

## Operation
- Entry fields are valid, rd, regwrite, is_load, data and rdy.
- Advance occurs when hold=0:
  - stage k ← stage k-1 for k ≥ 1;
  - stage 0 ← input with valid = in_valid & !flush;
  - rdy = !in_is_load;
  - data = in_is_load ? 0 : in_data.
- Load capture: on advance from stage LOAD_STAGE-1 into LOAD_STAGE, a valid load entry takes data ← ld_data and rdy ← 1.
- The oldest entry leaves the chain on advance; there is no backpressure downstream.
- When hold=1, all stages keep their contents. If flush=1 in the same cycle, stage 0 valid is cleared and the other stages are unaffected.
- When hold=0 and flush=1, the incoming entry is discarded and stage 0 becomes a bubble.
- Forwarding for operand i, evaluated combinationally over the current chain contents:
  - A match at stage k requires valid & regwrite & rd==src_idx[i] & src_idx[i]≠0.
  - The lowest k wins (youngest).
  - fwd_hit[i] is 1 on any match.
  - fwd_data[i] is the winner's data, or 0 when there is no hit.
- stall_req is the OR over operands of (hit & winning entry rdy==0). fwd_data is don't-care in that case, but it must still equal the winner's data field (0).
- An older matching entry never overrides a younger one, even when the younger entry is not ready.
- wb_we = valid & regwrite & (rd≠0) of stage DEPTH-1; wb_rd and wb_data are that stage's fields, driven directly from registers.

## Timing
- Reset: every stage has valid=0, rd=0, data=0 and rdy=1. Consequently fwd_hit=0, fwd_data=0, stall_req=0, wb_we=0, wb_rd=0 and wb_data=0 in the cycle after reset is sampled high.
- Reset overrides hold and flush.
- An entry accepted at edge t is forwardable from cycle t+1 (stage 0). It appears on wb_* during cycle t+DEPTH-1 after acceptance, assuming no hold, i.e. after DEPTH advances it leaves.
- A load's data is forwardable once the entry is in stage ≥ LOAD_STAGE. With the defaults, a load-use dependency in the next instruction gives exactly one stall_req cycle, provided the caller inserts a bubble by holding the front end and advancing.
- Each hold cycle adds one cycle of latency per held entry. Outputs stay stable throughout hold.
- Forwarding and stall logic is purely combinational from registers and src_idx. It has no dependence on in_* or ld_data in the same cycle.

## Test plan
- Reset mid-stream: fill 3 entries, assert reset one cycle → all outputs 0 the next cycle and no wb_we for the flushed entries.
- Straight flow: accept rd=5, data=0x11 at t, with no hold → wb_we=1, wb_rd=5, wb_data=0x11 during cycle t+2. While in stage 0, src_idx=5 gives fwd_hit=1 and fwd_data=0x11.
- Youngest priority: accept rd=7 data=0xAA, then rd=7 data=0xBB; query 7 → fwd_data=0xBB. Query 0 with rd=0 entries present → fwd_hit=0.
- Load-use: accept a load with rd=3, query src=3 → stall_req=1. Advance with ld_data=0xDEAD → stall_req=0, fwd_data=0xDEAD, and wb_data=0xDEAD on retirement.
- Flush and hold combined: hold=1 and flush=1 with entries in stages 0–2 → stage 0 is cleared. The stage 1–2 entries keep their values and retire in order after hold drops.
- Parameter sweep: DEPTH=4, LOAD_STAGE=2, NSRC=3, XLEN=64 → latency is 4 advances, two stall cycles for load-use, and independent per-operand hits.
